video_shift_sched: RTL and testbench
====================================

# video_shift_sched

Scheduler for the 8-bit PISO pixel shifter in the SE-VGA video path. On each active line it fetches `BYTES_PER_LINE` framebuffer bytes through a req/ack handshake and holds one byte in a prefetch register. Every 8 clocks it drives the shifter's `load`/`parIn`, and it flags which shifter output bits are valid pixels. It sits between the line-buffer read port and the `piso8` shifter, which clocks on the same `clk`.

## Interface
- `BYTES_PER_LINE`, default 64: bytes loaded per line; legal range 1..255.
- `clk`  in  1  pixel clock; shared with the shifter.
- `nReset`  in  1  asynchronous, active-low reset.
- `lineStart`  in  1  one-clock pulse that starts a line.
- `fetchReq`  out  1  request for the next framebuffer byte.
- `fetchAck`  in  1  `fetchData` is valid this cycle. Ignored while `fetchReq`=0.
- `fetchData`  in  8  framebuffer byte.
- `load`  out  1  to the shifter's `load`.
- `parOut`  out  8  to the shifter's `parIn`.
- `pixActive`  out  1  the shifter's serial output is a valid pixel this cycle.
- `lineDone`  out  1  one-clock pulse at the end of a line.
- `underrun`  out  1  sticky flag; at least one byte this line was a fill byte.
- `underrunCount`  out  8  saturating underrun counter. Present only with the macro.

## Operation
- Reset: state IDLE. `fetchReq`, `load`, `parOut`, `pixActive`, `lineDone`, `underrun` and `underrunCount` are all 0. The hold register is empty and all counters are 0.
- States:
  - IDLE: `fetchReq`=0.
  - FILL: waits for the first byte.
  - RUN: shifting the line.
- `lineStart` in any state:
  - Next state FILL; `bitCnt`, `loadCnt` and `fetchCnt` cleared; hold register emptied; `pixActive` and `underrun` cleared.
  - A restart mid-line does not pulse `lineDone`.
- `fetchReq` = (state is FILL or RUN) & hold empty & `fetchCnt` < `BYTES_PER_LINE`. It is combinational.
- When `fetchReq` and `fetchAck` are both high, `fetchData` is captured into hold and `fetchCnt` increments.
- FILL to RUN happens on the edge after hold becomes valid. `bitCnt` enters RUN at 0.
- In RUN, `bitCnt` increments mod 8 each clock.
- `load`=1 iff the state is RUN, `bitCnt`==0 and `loadCnt` < `BYTES_PER_LINE`.
  - If hold is valid: `parOut` = hold and hold is consumed.
  - If hold is empty: `parOut` = `FILL_BYTE` (8'h00), `underrun` is set, and `underrunCount` increments.
  - In both cases `loadCnt` increments, so line timing never slips.
- Load and ack in the same cycle: the underrun decision uses the hold state registered before that edge. An ack in that cycle fills hold for the next load.
- While `load`=0, `parOut` holds its last value.
- End of line: in RUN with `bitCnt`==0 and `loadCnt`==`BYTES_PER_LINE`, the next state is IDLE and `lineDone`=1 for that cycle. `pixActive` goes to 0 on that edge.
- `pixActive` is registered. It is set on every edge where `load`=1 and cleared at end of line or on `lineStart`.
- Serial pixel order is MSB first, as produced by the shifter.

## Timing
- `lineStart` at edge 0: FILL in cycle 1, with `fetchReq` high in cycle 1.
- Ack in cycle k: RUN and `load` in cycle k+1. `pixActive` and the first pixel appear in cycle k+2.
- `pixActive` stays high for exactly 8×`BYTES_PER_LINE` consecutive cycles.
- `lineDone` is asserted in the first cycle after the last pixel.
- Each subsequent byte must be acked within 7 cycles of the previous load to avoid an underrun.
- Asserting `nReset` mid-line returns the block to reset values immediately.

## Configuration
- `SEVGA_UNDERRUN_CNT_EN` defined:
  - The `underrunCount` port exists.
  - It increments once per fill-byte load and saturates at 255.
  - It is cleared only by `nReset`, not by `lineStart`.
- Undefined: the port and its counter are absent. The `underrun` flag behaves identically in both builds.

## Structure
- Shared package `sevga_pkg` holds:
  - the state enum (IDLE, FILL, RUN)
  - `FILL_BYTE` = 8'h00
  - `DEFAULT_BYTES_PER_LINE` = 64
- Sub-module `fetch_hold`: the single-entry prefetch register. It has a valid flag and capture/consume inputs, and it clears on `lineStart` or reset.
- Top level: FSM, `bitCnt`, `loadCnt`, `fetchCnt`, and the `pixActive`/`underrun` registers.

## Test plan
- Reset: hold `nReset` low mid-RUN -> all outputs 0 and state IDLE; after release, `fetchReq` stays 0 until `lineStart`.
- Zero-wait line with N=4 and bytes A5, 3C, FF, 01 -> first load in cycle 2; `pixActive` high cycles 3–34; serial output starts 1,0,1,0,0,1,0,1; `lineDone` in cycle 35; exactly 4 acks.
- Late ack (N=4, byte 2 acked 12 cycles after load 1) -> load 2 carries 00; `underrun`=1 until the next `lineStart`; `underrunCount`=1; `pixActive` still lasts 32 cycles.
- `lineStart` re-pulsed at cycle 10 of a line -> no `lineDone`; `pixActive` drops; a new FILL starts and the new line completes normally.
- Backpressure: with ack held high continuously -> `fetchReq` never high while hold is full; `fetchCnt`=N per line.
- Macro on: 300 fill-byte loads across lines -> `underrunCount` = 255; `lineStart` does not clear it.

Source files
------------

// File: rtl/video_shift_sched_pkg.sv
// ============================================================================
// sevga_pkg : shared types and constants for the SE-VGA pixel scheduler
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package sevga_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam logic [7:0] FILL_BYTE              = 8'h00;
  localparam int         DEFAULT_BYTES_PER_LINE = 64;

endpackage

`default_nettype wire

// File: rtl/video_shift_sched_if.sv
// ============================================================================
// video_shift_sched_if : fetch handshake and shifter-side signals
// Optional feature macro: SEVGA_UNDERRUN_CNT_EN (adds underrunCount)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface video_shift_sched_if;
  import sevga_pkg::*;

  logic       lineStart;
  logic       fetchReq;
  logic       fetchAck;
  logic [7:0] fetchData;
  logic       load;
  logic [7:0] parOut;
  logic       pixActive;
  logic       lineDone;
  logic       underrun;
`ifdef SEVGA_UNDERRUN_CNT_EN
  logic [7:0] underrunCount;
`endif

  modport master (
    input  lineStart, fetchAck, fetchData,
    output fetchReq, load, parOut, pixActive, lineDone, underrun
`ifdef SEVGA_UNDERRUN_CNT_EN
    , output underrunCount
`endif
  );

  modport slave (
    output lineStart, fetchAck, fetchData,
    input  fetchReq, load, parOut, pixActive, lineDone, underrun
`ifdef SEVGA_UNDERRUN_CNT_EN
    , input underrunCount
`endif
  );

endinterface

`default_nettype wire

// File: rtl/video_shift_sched_fetch_hold.sv
// ============================================================================
// fetch_hold : single-entry prefetch register between fetch and shifter load
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module fetch_hold (
  input  logic       clk,
  input  logic       nReset,
  input  logic       clear,
  input  logic       capture,
  input  logic       consume,
  input  logic [7:0] data_in,
  output logic       valid,
  output logic [7:0] data_out
);

  // Capture wins over consume so an ack during a fill-byte load refills hold.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      valid    <= 1'b0;
      data_out <= 8'h00;
    end else if (clear) begin
      valid    <= 1'b0;
    end else if (capture) begin
      valid    <= 1'b1;
      data_out <= data_in;
    end else if (consume) begin
      valid    <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/video_shift_sched.sv
// ============================================================================
// video_shift_sched : per-line byte fetch and load scheduler for piso8
// Optional feature macro: SEVGA_UNDERRUN_CNT_EN (saturating underrun counter)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module video_shift_sched
  import sevga_pkg::*;
#(
  parameter int BYTES_PER_LINE = DEFAULT_BYTES_PER_LINE
) (
  input  logic                 clk,
  input  logic                 nReset,
  video_shift_sched_if.master  bus
);

  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_FILL     = FILL;
  localparam logic [1:0] S_RUN      = RUN;
  localparam logic [7:0] LINE_BYTES = 8'(BYTES_PER_LINE);

  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] load_cnt;
  logic [7:0] fetch_cnt;
  logic [7:0] par_q;
  logic       pix_q;
  logic       und_q;
  logic       done_q;

  logic       hold_valid;
  logic [7:0] hold_data;
  logic       fetch_req;
  logic       capture;
  logic       load;
  logic       line_end;
  logic [7:0] par_out;

  assign fetch_req = (state != S_IDLE) && !hold_valid && (fetch_cnt < LINE_BYTES);
  assign capture   = fetch_req && bus.fetchAck && !bus.lineStart;
  assign load      = (state == S_RUN) && (bit_cnt == 3'd0) && (load_cnt < LINE_BYTES);
  assign line_end  = (state == S_RUN) && (bit_cnt == 3'd0) && (load_cnt == LINE_BYTES);
  assign par_out   = load ? (hold_valid ? hold_data : FILL_BYTE) : par_q;

  fetch_hold u_hold (
    .clk      (clk),
    .nReset   (nReset),
    .clear    (bus.lineStart),
    .capture  (capture),
    .consume  (load && hold_valid),
    .data_in  (bus.fetchData),
    .valid    (hold_valid),
    .data_out (hold_data)
  );

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= S_IDLE;
      bit_cnt   <= 3'd0;
      load_cnt  <= 8'd0;
      fetch_cnt <= 8'd0;
      pix_q     <= 1'b0;
      und_q     <= 1'b0;
      done_q    <= 1'b0;
    end else if (bus.lineStart) begin
      state     <= S_FILL;
      bit_cnt   <= 3'd0;
      load_cnt  <= 8'd0;
      fetch_cnt <= 8'd0;
      pix_q     <= 1'b0;
      und_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // lineDone lands in the idle cycle right after the last pixel.
      done_q <= line_end;
      if (capture) fetch_cnt <= fetch_cnt + 8'd1;
      if (load) begin
        load_cnt <= load_cnt + 8'd1;
        pix_q    <= 1'b1;
        if (!hold_valid) und_q <= 1'b1;
      end
      case (state)
        S_IDLE: ;
        S_FILL: begin
          if (hold_valid || capture) begin
            state   <= S_RUN;
            bit_cnt <= 3'd0;
          end
        end
        S_RUN: begin
          if (line_end) begin
            state   <= S_IDLE;
            pix_q   <= 1'b0;
            bit_cnt <= 3'd0;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) par_q <= 8'h00;
    else if (load) par_q <= par_out;
  end

`ifdef SEVGA_UNDERRUN_CNT_EN
  logic [7:0] und_cnt;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) und_cnt <= 8'd0;
    else if (load && !hold_valid && (und_cnt != 8'hFF)) und_cnt <= und_cnt + 8'd1;
  end

  assign bus.underrunCount = und_cnt;
`endif

  assign bus.fetchReq  = fetch_req;
  assign bus.load      = load;
  assign bus.parOut    = par_out;
  assign bus.pixActive = pix_q;
  assign bus.lineDone  = done_q;
  assign bus.underrun  = und_q;

endmodule

`default_nettype wire

// File: tb/tb_video_shift_sched.sv
// ============================================================================
// tb_video_shift_sched : scoreboard bench for video_shift_sched (N = 4)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_video_shift_sched;
  import sevga_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic nReset = 1'b0;

  video_shift_sched_if bus ();

  video_shift_sched #(.BYTES_PER_LINE(N)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Reference model of the downstream piso8 shifter, MSB first.
  logic [7:0] sreg = 8'h00;
  always @(posedge clk) begin
    if (bus.load) sreg <= bus.parOut;
    else          sreg <= {sreg[6:0], 1'b0};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_load[$];
  logic       exp_pix[$];

  task automatic expect_byte(input logic [7:0] b);
    exp_load.push_back(b);
    for (int i = 7; i >= 0; i--) exp_pix.push_back(b[i]);
  endtask

  int line_base = 0;
  int first_load, first_pix, last_pix, pix_count, ld_count, ld_rel, ack_count, bp_viol;
  int mon_rel;
  logic cap_prev = 1'b0;

  task automatic clear_stats();
    first_load = -1; first_pix = -1; last_pix = -1; pix_count = 0;
    ld_count = 0; ld_rel = -1; ack_count = 0; bp_viol = 0;
  endtask

  // Monitor: pops expectations whenever the DUT presents a load or a pixel.
  always @(negedge clk) begin
    mon_rel = cyc - line_base;
    if (nReset) begin
      if (bus.load) begin
        if (first_load < 0) first_load = mon_rel;
        if (exp_load.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL load_unexpected: parOut=%0h at rel cycle %0d, scoreboard empty", bus.parOut, mon_rel);
        end else check("parOut", 32'(bus.parOut), 32'(exp_load.pop_front()));
      end
      if (bus.pixActive) begin
        if (first_pix < 0) first_pix = mon_rel;
        last_pix = mon_rel;
        pix_count++;
        if (exp_pix.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL pixel_unexpected: pixActive at rel cycle %0d, scoreboard empty", mon_rel);
        end else check("pixel", 32'(sreg[7]), 32'(exp_pix.pop_front()));
      end
      if (bus.lineDone) begin
        ld_count++;
        ld_rel = mon_rel;
      end
      if (cap_prev && bus.fetchReq) bp_viol++;
      cap_prev = bus.fetchReq && bus.fetchAck;
      if (cap_prev) ack_count++;
    end else begin
      cap_prev = 1'b0;
    end
  end

  // Responder state
  logic [7:0] bytes[N];
  int         delay[N];
  int         n_bytes = 0;
  int         byte_idx = 0;
  int         wait_cnt = 0;
  bit         ack_pend = 0;
  bit         ack_hold = 0;

  task automatic set_line(input logic [31:0] bv, input int d1);
    for (int i = 0; i < N; i++) begin
      bytes[i] = bv[31-8*i -: 8];
      delay[i] = 0;
    end
    delay[1] = d1;
    n_bytes  = N;
  endtask

  task automatic step(input bit ls);
    @(posedge clk);
    #1;
    if (ack_pend) begin
      byte_idx++;
      wait_cnt = 0;
    end
    ack_pend = 0;
    if (ls) begin
      byte_idx  = 0;
      wait_cnt  = 0;
      line_base = cyc;
    end
    bus.lineStart = ls;
    bus.fetchAck  = ack_hold;
    bus.fetchData = 8'h00;
    if (byte_idx < n_bytes) bus.fetchData = bytes[byte_idx];
    if (!ls && bus.fetchReq && byte_idx < n_bytes) begin
      if (wait_cnt >= delay[byte_idx]) begin
        bus.fetchAck = 1'b1;
        ack_pend     = 1;
      end else begin
        wait_cnt++;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_fetchReq"},  32'(bus.fetchReq),  0);
    check({tag, "_load"},      32'(bus.load),      0);
    check({tag, "_parOut"},    32'(bus.parOut),    0);
    check({tag, "_pixActive"}, 32'(bus.pixActive), 0);
    check({tag, "_lineDone"},  32'(bus.lineDone),  0);
    check({tag, "_underrun"},  32'(bus.underrun),  0);
`ifdef SEVGA_UNDERRUN_CNT_EN
    check({tag, "_underrunCount"}, 32'(bus.underrunCount), 0);
`endif
  endtask

  task automatic check_line(input string tag, input int e_pix, input int e_acks);
    check({tag, "_first_pix"}, first_pix, 3);
    check({tag, "_last_pix"},  last_pix,  34);
    check({tag, "_pix_count"}, pix_count, e_pix);
    check({tag, "_lineDone_count"}, ld_count, 1);
    check({tag, "_lineDone_cycle"}, ld_rel, 35);
    check({tag, "_acks"}, ack_count, e_acks);
    check({tag, "_load_queue_left"}, exp_load.size(), 0);
    check({tag, "_pix_queue_left"},  exp_pix.size(),  0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.lineStart = 1'b0;
    bus.fetchAck  = 1'b0;
    bus.fetchData = 8'h00;
    clear_stats();

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("por");
    nReset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(0);
      check("idle_fetchReq", 32'(bus.fetchReq), 0);
    end

    // Zero-wait line
    set_line(32'hA53CFF01, 0);
    expect_byte(8'hA5); expect_byte(8'h3C); expect_byte(8'hFF); expect_byte(8'h01);
    clear_stats();
    step(1);
    step(0);
    check("zw_fetchReq_cycle1", 32'(bus.fetchReq), 1);
    repeat (39) step(0);
    check("zw_first_load", first_load, 2);
    check_line("zw", 32, 4);
    check("zw_underrun", 32'(bus.underrun), 0);

    // Late ack on byte 2 -> one fill byte
    set_line(32'hA53CFF01, 11);
    expect_byte(8'hA5); expect_byte(8'h00); expect_byte(8'h3C); expect_byte(8'hFF);
    clear_stats();
    step(1);
    repeat (40) step(0);
    check("late_first_load", first_load, 2);
    check_line("late", 32, 4);
    check("late_underrun", 32'(bus.underrun), 1);
`ifdef SEVGA_UNDERRUN_CNT_EN
    check("late_underrunCount", 32'(bus.underrunCount), 1);
`endif
    repeat (3) step(0);
    check("late_underrun_sticky", 32'(bus.underrun), 1);

    // Restart mid-line at cycle 10
    set_line(32'hA53CFF01, 0);
    expect_byte(8'hA5);
    exp_load.push_back(8'h3C);
    clear_stats();
    step(1);
    repeat (9) step(0);
    check("rs_underrun_cleared", 32'(bus.underrun), 0);
    set_line(32'h81422418, 0);
    expect_byte(8'h81); expect_byte(8'h42); expect_byte(8'h24); expect_byte(8'h18);
    step(1);
    step(0);
    check("rs_pixActive_drop", 32'(bus.pixActive), 0);
    check("rs_fetchReq_fill",  32'(bus.fetchReq),  1);
    repeat (39) step(0);
    check_line("rs", 40, 6);

    // Backpressure: ack held high
    ack_hold = 1;
    for (int l = 0; l < 2; l++) begin
      set_line((l == 0) ? 32'h11223344 : 32'h55667788, 0);
      for (int i = 0; i < N; i++) expect_byte(bytes[i]);
      clear_stats();
      step(1);
      repeat (40) step(0);
      check("bp_acks", ack_count, N);
      check("bp_req_while_full", bp_viol, 0);
      check("bp_lineDone", ld_count, 1);
    end
    ack_hold = 0;

    // Reset asserted mid-RUN
    set_line(32'hA53CFF01, 0);
    expect_byte(8'hA5);
    exp_load.push_back(8'h3C);
    exp_pix.push_back(1'b0); exp_pix.push_back(1'b0);
    exp_pix.push_back(1'b1); exp_pix.push_back(1'b1);
    clear_stats();
    step(1);
    repeat (15) step(0);
    nReset = 1'b0;
    #1;
    check_idle_outputs("rst");
    check("rst_load_queue_left", exp_load.size(), 0);
    check("rst_pix_queue_left",  exp_pix.size(),  0);
    repeat (2) step(0);
    nReset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(0);
      check("rst_idle_fetchReq", 32'(bus.fetchReq), 0);
    end

`ifdef SEVGA_UNDERRUN_CNT_EN
    // 100 lines of one real byte and three fill bytes -> 300 fill loads
    n_bytes  = 1;
    bytes[0] = 8'hC3;
    for (int i = 0; i < N; i++) delay[i] = 0;
    for (int l = 0; l < 100; l++) begin
      expect_byte(8'hC3); expect_byte(8'h00); expect_byte(8'h00); expect_byte(8'h00);
      clear_stats();
      step(1);
      repeat (36) step(0);
      if (l == 49) check("cnt_mid", 32'(bus.underrunCount), 150);
    end
    check("cnt_saturated", 32'(bus.underrunCount), 255);
    check("cnt_underrun_flag", 32'(bus.underrun), 1);
    expect_byte(8'hC3); expect_byte(8'h00); expect_byte(8'h00); expect_byte(8'h00);
    clear_stats();
    step(1);
    step(0);
    check("cnt_kept_on_lineStart", 32'(bus.underrunCount), 255);
    check("cnt_flag_cleared", 32'(bus.underrun), 0);
    repeat (36) step(0);
    check("cnt_last_lineDone", ld_count, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
